regfile_wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: req0 (ALU result) and req1 (load result).
- Uses round-robin arbitration with valid/ready handshakes.
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file's write port (write_enable, addrC, data_in_C).

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants: address/data widths, the hard-wired zero
// register and the writeback requester indices used by the arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The requester that did not win the most recent
// handshake gets priority on contention; a lone requester always wins.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the requester granted at the last handshake.
  logic last_gnt;

  // Grant selection: contention resolved against the last winner.
  always_comb begin
    gnt = req;
    if (req[WB_ALU] && req[WB_LOAD]) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

  // Pointer follows every handshake; reset favours the ALU on first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      last_gnt <= gnt[WB_LOAD];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port. Grants one of
// the ALU/load requesters per cycle, registers the winning write, and keeps a
// pending-write scoreboard that the issue stage reads for RAW hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  input  logic                 claim_valid,
  input  logic [ADDR_W-1:0]    claim_addr,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 sb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic [1:0]        gnt;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_nxt;
  logic              err_set;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[WB_ALU];
  assign req1_ready = gnt[WB_LOAD];
  assign hs         = |gnt;
  assign sel_addr   = gnt[WB_LOAD] ? req1_addr : req0_addr;
  assign sel_data   = gnt[WB_LOAD] ? req1_data : req0_data;

  // No bypass: a register stays hazardous until the edge that commits it.
  assign hazard_a = busy[rd_addr_a];
  assign hazard_b = busy[rd_addr_b];

  // Write stage: capture the granted write; r0 writes are accepted but dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (hs) begin
      wr_en   <= (sel_addr != ZERO_ADDR);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Scoreboard next state: commit clears, claim sets and wins a same-edge tie.
  always_comb begin
    busy_nxt = busy;
    err_set  = 1'b0;
    if (wr_en) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (claim_valid && (claim_addr != ZERO_ADDR)) begin
      if (busy[claim_addr] && !(wr_en && (wr_addr == claim_addr))) begin
        err_set = 1'b1;
      end
      busy_nxt[claim_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard and sticky double-claim flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      sb_err <= sb_err | err_set;
    end
  end

endmodule
